// File: rtl/n_clic_pend_ctrl.sv
// n_clic_pend_ctrl: per-vector pend controller that drives the N-CLIC entry
// CSR external write ports from raw interrupt lines and clears them on take.
module n_clic_pend_ctrl #(
   parameter int unsigned          VecSize    = 8,
   parameter int unsigned          PrioLevels = 8,
   parameter logic [VecSize-1:0]   EdgeMask   = '1,
   parameter int unsigned          OvfWidth   = 4,
   localparam int unsigned         VecWidth   = $clog2(VecSize),
   localparam int unsigned         PrioWidth  = $clog2(PrioLevels),
   localparam int unsigned         EntryWidth = PrioWidth + 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [VecSize-1:0]                   irq,
   input  logic [VecSize-1:0][EntryWidth-1:0]   entry_in,
   input  logic                                 take_valid,
   input  logic [VecWidth-1:0]                  take_vec,
   output logic [VecSize-1:0]                   ext_write_enable,
   output logic [VecSize-1:0][EntryWidth-1:0]   ext_entry_data,
   output logic [VecSize-1:0][OvfWidth-1:0]     overrun,
   output logic                                 busy
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PENDED   = 2'd1,
      SERVICED = 2'd2
   } state_e;

   state_e                               state_q [VecSize];
   state_e                               state_d [VecSize];
   logic [VecSize-1:0]                   meta_q, meta_d;
   logic [VecSize-1:0]                   sync_q, sync_d;
   logic [VecSize-1:0]                   sync_dly_q, sync_dly_d;
   logic [VecSize-1:0]                   we_q, we_d;
   logic [VecSize-1:0][EntryWidth-1:0]   data_q, data_d;
   logic [VecSize-1:0][OvfWidth-1:0]     ovf_q, ovf_d;
   logic                                 busy_q, busy_d;
   logic [VecSize-1:0]                   rise_c;
   logic [VecSize-1:0]                   hit_c;

   // Two-flop synchronizer plus one delay stage for edge detection
   always_comb begin
      meta_d     = irq;
      sync_d     = meta_q;
      sync_dly_d = sync_q;
      rise_c     = sync_q & ~sync_dly_q;
   end

   // Decode the taken vector; out-of-range indices match nothing
   always_comb begin
      hit_c = '0;
      for (int k = 0; k < VecSize; k++) begin
         hit_c[k] = take_valid && (32'(take_vec) == 32'(k));
      end
   end

   // Per-vector next state, write strobes, write data and overrun counters
   always_comb begin
      logic inflight;
      logic cur_pend;
      logic wr;
      logic new_pend;
      state_d  = state_q;
      we_d     = '0;
      data_d   = data_q;
      ovf_d    = ovf_q;
      busy_d   = 1'b0;
      inflight = 1'b0;
      cur_pend = 1'b0;
      wr       = 1'b0;
      new_pend = 1'b0;
      for (int k = 0; k < VecSize; k++) begin
         // entry_in lags our own strobe by a cycle, so skip coherence then
         inflight = we_q[k];
         cur_pend = entry_in[k][0];
         wr       = 1'b0;
         new_pend = 1'b0;
         unique case (state_q[k])
            IDLE: begin
               if (cur_pend && !inflight) begin
                  state_d[k] = PENDED;
               end else if (EdgeMask[k] ? rise_c[k] : sync_q[k]) begin
                  state_d[k] = PENDED;
                  wr         = 1'b1;
                  new_pend   = 1'b1;
               end
            end
            PENDED: begin
               if (!cur_pend && !inflight) begin
                  state_d[k] = IDLE;
               end else if (EdgeMask[k]) begin
                  if (hit_c[k] && !rise_c[k]) begin
                     state_d[k] = IDLE;
                     wr         = 1'b1;
                  end else if (rise_c[k] && !hit_c[k] && (ovf_q[k] != '1)) begin
                     ovf_d[k] = ovf_q[k] + OvfWidth'(1);
                  end
               end else if (hit_c[k]) begin
                  state_d[k] = SERVICED;
                  wr         = 1'b1;
               end
            end
            SERVICED: begin
               if (!sync_q[k]) begin
                  state_d[k] = IDLE;
               end
            end
            default: state_d[k] = IDLE;
         endcase
         if (wr) begin
            we_d[k]   = 1'b1;
            data_d[k] = {entry_in[k][EntryWidth-1:1], new_pend};
         end
         if (state_d[k] != IDLE) begin
            busy_d = 1'b1;
         end
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q     <= '0;
         sync_q     <= '0;
         sync_dly_q <= '0;
         we_q       <= '0;
         data_q     <= '0;
         ovf_q      <= '0;
         busy_q     <= 1'b0;
         state_q    <= '{default: IDLE};
      end else begin
         meta_q     <= meta_d;
         sync_q     <= sync_d;
         sync_dly_q <= sync_dly_d;
         we_q       <= we_d;
         data_q     <= data_d;
         ovf_q      <= ovf_d;
         busy_q     <= busy_d;
         state_q    <= state_d;
      end
   end

   assign ext_write_enable = we_q;
   assign ext_entry_data   = data_q;
   assign overrun          = ovf_q;
   assign busy             = busy_q;

endmodule

// File: tb/tb_n_clic_pend_ctrl.sv
// Directed bench for n_clic_pend_ctrl with a strobe scoreboard and CSR model.
module tb_n_clic_pend_ctrl;

   logic             clk = 1'b0;
   logic             reset;
   logic [7:0]       irq;
   logic [7:0][4:0]  csr;
   logic             take_valid;
   logic [2:0]       take_vec;
   logic [7:0]       ext_write_enable;
   logic [7:0][4:0]  ext_entry_data;
   logic [7:0][3:0]  overrun;
   logic             busy;

   logic             sw_wr;
   int               sw_idx;
   logic [4:0]       sw_val;

   int               total = 0;
   int               bad   = 0;
   logic [7:0]       sb [$];

   n_clic_pend_ctrl #(
      .VecSize   (8),
      .PrioLevels(8),
      .EdgeMask  (8'hDF),
      .OvfWidth  (4)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .irq             (irq),
      .entry_in        (csr),
      .take_valid      (take_valid),
      .take_vec        (take_vec),
      .ext_write_enable(ext_write_enable),
      .ext_entry_data  (ext_entry_data),
      .overrun         (overrun),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   // CSR array model: init prio=k, enabled=1, pended=0; hardware and software writes
   always @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 8; k++) csr[k] <= {3'(k), 1'b1, 1'b0};
      end else begin
         for (int k = 0; k < 8; k++) if (ext_write_enable[k]) csr[k] <= ext_entry_data[k];
         if (sw_wr) csr[sw_idx] <= sw_val;
      end
   end

   // Scoreboard: every strobe must match the next expected {vec, data}
   always @(negedge clk) begin
      logic [7:0] exp_item;
      logic [7:0] obs_item;
      if (!reset) begin
         for (int k = 0; k < 8; k++) begin
            if (ext_write_enable[k]) begin
               total++;
               obs_item = {3'(k), ext_entry_data[k]};
               if (sb.size() == 0) begin
                  bad++;
                  $error("FAIL sb_unexpected observed=%0h expected=none", obs_item);
               end else begin
                  exp_item = sb.pop_front();
                  assert (obs_item === exp_item) else begin
                     bad++;
                     $error("FAIL sb_strobe observed=%0h expected=%0h", obs_item, exp_item);
                  end
               end
            end
         end
      end
   end

   function automatic logic [7:0] item(input int v, input logic p);
      return {3'(v), 3'(v), 1'b1, p};
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input int v);
      irq[v] = 1'b1;
      cyc(1);
      irq[v] = 1'b0;
   endtask

   task automatic take(input int v);
      take_valid = 1'b1;
      take_vec   = 3'(v);
      cyc(1);
      take_valid = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      irq        = '0;
      take_valid = 1'b0;
      take_vec   = '0;
      sw_wr      = 1'b0;
      sw_idx     = 0;
      sw_val     = '0;
      cyc(3);
      reset = 1'b0;
      chk("rst_we", 64'(ext_write_enable), 64'h0);
      chk("rst_data", 64'(ext_entry_data), 64'h0);
      chk("rst_ovf", 64'(overrun), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      cyc(2);

      // Edge pend and take on vector 3
      sb.push_back(item(3, 1'b1));
      pulse(3);
      cyc(1);
      chk("v3_no_early", 64'(ext_write_enable), 64'h0);
      cyc(1);
      chk("v3_pend_we", 64'(ext_write_enable), 64'h08);
      cyc(1);
      chk("v3_one_cycle", 64'(ext_write_enable), 64'h0);
      chk("v3_busy", 64'(busy), 64'h1);
      cyc(3);
      sb.push_back(item(3, 1'b0));
      take(3);
      chk("v3_clr_we", 64'(ext_write_enable), 64'h08);
      chk("v3_idle", 64'(busy), 64'h0);
      cyc(3);
      chk("v3_stays_idle", 64'(busy), 64'h0);

      // Overrun on vector 2
      sb.push_back(item(2, 1'b1));
      pulse(2);
      cyc(5);
      for (int i = 0; i < 20; i++) begin
         irq[2] = 1'b1;
         cyc(2);
         irq[2] = 1'b0;
         cyc(2);
         if (i == 4) chk("v2_ovf_5", 64'(overrun[2]), 64'd5);
      end
      cyc(4);
      chk("v2_ovf_sat", 64'(overrun[2]), 64'd15);
      chk("v2_busy", 64'(busy), 64'h1);
      sb.push_back(item(2, 1'b0));
      take(2);
      chk("v2_clr_we", 64'(ext_write_enable), 64'h04);
      cyc(3);
      chk("v2_ovf_hold", 64'(overrun[2]), 64'd15);
      chk("v2_idle", 64'(busy), 64'h0);

      // Level-once on vector 5
      sb.push_back(item(5, 1'b1));
      irq[5] = 1'b1;
      cyc(3);
      chk("v5_pend_we", 64'(ext_write_enable), 64'h20);
      cyc(3);
      sb.push_back(item(5, 1'b0));
      take(5);
      chk("v5_clr_we", 64'(ext_write_enable), 64'h20);
      cyc(10);
      chk("v5_serviced_busy", 64'(busy), 64'h1);
      irq[5] = 1'b0;
      cyc(4);
      chk("v5_idle", 64'(busy), 64'h0);
      sb.push_back(item(5, 1'b1));
      irq[5] = 1'b1;
      cyc(3);
      chk("v5_repend_we", 64'(ext_write_enable), 64'h20);
      cyc(2);
      sb.push_back(item(5, 1'b0));
      take(5);
      irq[5] = 1'b0;
      cyc(5);
      chk("v5_done", 64'(busy), 64'h0);

      // Rise and hit in the same cycle on vector 1
      sb.push_back(item(1, 1'b1));
      pulse(1);
      cyc(5);
      irq[1] = 1'b1;
      cyc(1);
      irq[1] = 1'b0;
      cyc(1);
      take(1);
      chk("v1_sim_no_we", 64'(ext_write_enable), 64'h0);
      cyc(3);
      chk("v1_sim_ovf", 64'(overrun[1]), 64'd0);
      chk("v1_sim_busy", 64'(busy), 64'h1);
      sb.push_back(item(1, 1'b0));
      take(1);
      chk("v1_clr_we", 64'(ext_write_enable), 64'h02);
      cyc(2);
      chk("v1_idle", 64'(busy), 64'h0);

      // Software clear on vector 4, then spurious take
      sb.push_back(item(4, 1'b1));
      pulse(4);
      cyc(5);
      chk("v4_busy", 64'(busy), 64'h1);
      sw_wr  = 1'b1;
      sw_idx = 4;
      sw_val = {3'd4, 1'b1, 1'b0};
      cyc(1);
      sw_wr = 1'b0;
      cyc(1);
      chk("v4_sw_idle", 64'(busy), 64'h0);
      chk("v4_sw_no_we", 64'(ext_write_enable), 64'h0);
      take(4);
      chk("v4_spurious", 64'(ext_write_enable), 64'h0);
      cyc(1);
      chk("v4_spurious2", 64'(ext_write_enable), 64'h0);

      // Software set on vector 6, then take without and with take_valid
      sw_wr  = 1'b1;
      sw_idx = 6;
      sw_val = {3'd6, 1'b1, 1'b1};
      cyc(1);
      sw_wr = 1'b0;
      cyc(1);
      chk("v6_sw_pend", 64'(busy), 64'h1);
      chk("v6_sw_no_we", 64'(ext_write_enable), 64'h0);
      take_vec = 3'd6;
      cyc(1);
      chk("v6_no_valid", 64'(ext_write_enable), 64'h0);
      sb.push_back(item(6, 1'b0));
      take(6);
      chk("v6_clr_we", 64'(ext_write_enable), 64'h40);
      cyc(2);
      chk("v6_idle", 64'(busy), 64'h0);

      // Reset in the cycle vector 0's strobe would fire
      pulse(0);
      cyc(1);
      reset = 1'b1;
      cyc(1);
      chk("mrst_we", 64'(ext_write_enable), 64'h0);
      chk("mrst_data", 64'(ext_entry_data), 64'h0);
      chk("mrst_ovf", 64'(overrun), 64'h0);
      chk("mrst_busy", 64'(busy), 64'h0);
      reset = 1'b0;
      cyc(4);
      chk("post_rst_we", 64'(ext_write_enable), 64'h0);
      chk("post_rst_busy", 64'(busy), 64'h0);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
